// File: rtl/gfg_pattern_rasterizer_pkg.sv
// Shared definitions for the pattern rasterizer: FSM states, pattern codes and
// the width of one frame-buffer word ({z, r, g, b}).
package gfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_DRAW    = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic [1:0] PAT_SOLID    = 2'd0;
   localparam logic [1:0] PAT_BARS     = 2'd1;
   localparam logic [1:0] PAT_CHECKER  = 2'd2;
   localparam logic [1:0] PAT_GRADIENT = 2'd3;

   localparam int COLOR_BITS         = 12;
   localparam int Z_BITS             = 2;
   localparam int FRAME_BUFFER_WIDTH = Z_BITS + COLOR_BITS;

endpackage

// File: rtl/gfg_pattern_rasterizer_color.sv
// Combinational pattern generator: maps (pattern, column, row, offset) to a
// 4:4:4 RGB value. Only the low nibble of row and offset ever affects colour.
module gfg_pattern_color
   import gfg_pkg::*;
#(
   parameter int HORIZ_RESOLUTION = 80,
   parameter int HW               = $clog2(HORIZ_RESOLUTION)
) (
   input  logic [1:0]    pattern,
   input  logic [HW-1:0] horiz,
   input  logic [3:0]    vert,
   input  logic [3:0]    offset,
   output logic [11:0]   rgb
);

   localparam int BAR_W = HORIZ_RESOLUTION / 8;

   logic [2:0] bar;

   always_comb begin
      bar = 3'(horiz / HW'(BAR_W));
      rgb = 12'h000;
      case (pattern)
         PAT_SOLID:    rgb = 12'h00F;
         PAT_BARS:     rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
         PAT_CHECKER:  rgb = (horiz[3] ^ vert[3]) ? 12'hFFF : 12'h000;
         // Nibble-wide sum so the red channel wraps modulo 16.
         PAT_GRADIENT: rgb = {horiz[3:0] + offset, vert, offset};
      endcase
   end

endmodule

// File: rtl/gfg_pattern_rasterizer.sv
// Frame rasterizer: on each new frame, reserves the frame buffer and writes every
// pixel of the selected pattern once. Define GFG_PATTERN_ANIMATE_EN to animate.
module gfg_pattern_rasterizer
   import gfg_pkg::*;
#(
   parameter int HORIZ_RESOLUTION = 80,
   parameter int VERT_RESOLUTION  = 60,
   parameter int COLOR_DEPTH      = 12,
   parameter int Z_DEPTH          = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                new_frame_initiated,
   input  logic [1:0]                          pattern_sel,
   input  logic                                write_reservation_granted,
   output logic                                write_reservation_request,
   output logic [$clog2(VERT_RESOLUTION)-1:0]  vert_write_addr,
   output logic [$clog2(HORIZ_RESOLUTION)-1:0] horiz_write_addr,
   output logic                                write_en,
   output logic [Z_DEPTH+COLOR_DEPTH-1:0]      write_pixel_data,
   output logic                                finished,
   output logic                                drawing_pool_empty,
   output logic                                overrun
);

   localparam int HW = $clog2(HORIZ_RESOLUTION);
   localparam int VW = $clog2(VERT_RESOLUTION);
   localparam int PW = Z_DEPTH + COLOR_DEPTH;
   localparam logic [HW-1:0] H_LAST = HW'(HORIZ_RESOLUTION - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VERT_RESOLUTION - 1);

   state_e        state_q, state_d;
   logic [1:0]    pat_q, pat_d;
   logic [HW-1:0] horiz_q, horiz_d;
   logic [VW-1:0] vert_q, vert_d;
   logic          we_q, we_d;
   logic [PW-1:0] pix_q, pix_d;
   logic          overrun_q, overrun_d;
   logic [3:0]    offset_lo;
   logic [11:0]   rgb_next;
   logic          last_px;

   assign last_px = (horiz_q == H_LAST) && (vert_q == V_LAST);

`ifdef GFG_PATTERN_ANIMATE_EN
   logic [7:0] offset_q, offset_d;

   always_comb begin
      offset_d = offset_q;
      if (state_q == ST_DONE) offset_d = offset_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) offset_q <= 8'd0;
      else     offset_q <= offset_d;
   end

   assign offset_lo = offset_q[3:0];
`else
   assign offset_lo = 4'd0;
`endif

   // Colour is computed for the address being loaded so data, address and
   // strobe all leave registers on the same edge.
   gfg_pattern_color #(
      .HORIZ_RESOLUTION(HORIZ_RESOLUTION),
      .HW              (HW)
   ) u_color (
      .pattern(pat_q),
      .horiz  (horiz_d),
      .vert   (vert_d[3:0]),
      .offset (offset_lo),
      .rgb    (rgb_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pat_q     <= 2'd0;
         horiz_q   <= '0;
         vert_q    <= '0;
         we_q      <= 1'b0;
         pix_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         horiz_q   <= horiz_d;
         vert_q    <= vert_d;
         we_q      <= we_d;
         pix_q     <= pix_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (new_frame_initiated)       state_d = ST_REQUEST;
         ST_REQUEST: if (write_reservation_granted) state_d = ST_DRAW;
         ST_DRAW:    if (last_px)                   state_d = ST_DONE;
         ST_DONE:                                   state_d = ST_IDLE;
         default:                                   state_d = ST_IDLE;
      endcase
   end

   // Addresses sit at zero outside DRAW, so entering DRAW starts at (0,0).
   always_comb begin
      pat_d   = pat_q;
      horiz_d = '0;
      vert_d  = '0;
      if ((state_q == ST_IDLE) && new_frame_initiated) pat_d = pattern_sel;
      if ((state_q == ST_DRAW) && !last_px) begin
         if (horiz_q == H_LAST) begin
            vert_d = vert_q + VW'(1);
         end else begin
            horiz_d = horiz_q + HW'(1);
            vert_d  = vert_q;
         end
      end
      we_d      = (state_d == ST_DRAW);
      pix_d     = we_d ? PW'(rgb_next) : '0;
      overrun_d = overrun_q | (new_frame_initiated && (state_q != ST_IDLE));
   end

   always_comb begin
      write_reservation_request = (state_q == ST_REQUEST);
      finished                  = (state_q == ST_DONE);
      drawing_pool_empty        = (state_q == ST_IDLE) || (state_q == ST_DONE);
      write_en                  = we_q;
      horiz_write_addr          = horiz_q;
      vert_write_addr           = vert_q;
      write_pixel_data          = pix_q;
      overrun                   = overrun_q;
   end

endmodule

// File: tb/tb_gfg_pattern_rasterizer.sv
// Self-checking bench for gfg_pattern_rasterizer: randomized frames compared with a
// behavioural pixel model; honours GFG_PATTERN_ANIMATE_EN for the offset model.
module tb_gfg_pattern_rasterizer;

   localparam int H = 80;
   localparam int V = 60;
   localparam int NPIX = H * V;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        new_frame_initiated = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        write_reservation_granted = 1'b0;
   logic        write_reservation_request;
   logic [5:0]  vert_write_addr;
   logic [6:0]  horiz_write_addr;
   logic        write_en;
   logic [13:0] write_pixel_data;
   logic        finished;
   logic        drawing_pool_empty;
   logic        overrun;

   gfg_pattern_rasterizer #(
      .HORIZ_RESOLUTION(H),
      .VERT_RESOLUTION (V),
      .COLOR_DEPTH     (12),
      .Z_DEPTH         (2)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .new_frame_initiated      (new_frame_initiated),
      .pattern_sel              (pattern_sel),
      .write_reservation_granted(write_reservation_granted),
      .write_reservation_request(write_reservation_request),
      .vert_write_addr          (vert_write_addr),
      .horiz_write_addr         (horiz_write_addr),
      .write_en                 (write_en),
      .write_pixel_data         (write_pixel_data),
      .finished                 (finished),
      .drawing_pool_empty       (drawing_pool_empty),
      .overrun                  (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int frames_done = 0;

   // Observer state, written only by the monitor below.
   logic [13:0] fb [NPIX];
   int  burst_len = 0;
   int  req_total = 0, fin_total = 0, we_total = 0;
   int  seq_err = 0, proto_err = 0;
   bit  prev_we = 1'b0;

   always @(posedge clk) begin
      #1;
      if (write_reservation_request) req_total++;
      if (finished) begin
         fin_total++;
         if (write_en) proto_err++;
      end
      if (write_en) begin
         if (!prev_we) begin
            burst_len = 0;
            for (int i = 0; i < NPIX; i++) fb[i] = 'x;
         end
         // The k-th write of a frame must land on column k%H of row k/H.
         if (int'(horiz_write_addr) != burst_len % H || int'(vert_write_addr) != burst_len / H)
            seq_err++;
         if (int'(horiz_write_addr) < H && int'(vert_write_addr) < V)
            fb[int'(vert_write_addr) * H + int'(horiz_write_addr)] = write_pixel_data;
         if (write_pixel_data[13:12] != 2'b00) proto_err++;
         burst_len++;
         we_total++;
      end else if (write_pixel_data != 14'd0) begin
         proto_err++;
      end
      prev_we = write_en;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_off();
`ifdef GFG_PATTERN_ANIMATE_EN
      return frames_done % 256;
`else
      return 0;
`endif
   endfunction

   function automatic int model_px(input int pat, input int h, input int v, input int off);
      int r, g, b, bar;
      case (pat)
         0: begin r = 0; g = 0; b = 15; end
         1: begin
            bar = h / (H / 8);
            r = ((bar / 4) % 2) * 15;
            g = ((bar / 2) % 2) * 15;
            b = (bar % 2) * 15;
         end
         2: begin r = ((h / 8 + v / 8) % 2) * 15; g = r; b = r; end
         default: begin r = (h + off) % 16; g = v % 16; b = off % 16; end
      endcase
      return r * 256 + g * 16 + b;
   endfunction

   task automatic start_frame(input int pat, input int d, output bit ok);
      @(negedge clk);
      pattern_sel = 2'(pat);
      new_frame_initiated = 1'b1;
      @(negedge clk);
      new_frame_initiated = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (write_reservation_request) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         repeat (d - 1) @(negedge clk);
         write_reservation_granted = 1'b1;
         @(negedge clk);
         write_reservation_granted = 1'b0;
         pattern_sel = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic wait_writes(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (write_en && burst_len >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_finish(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (finished) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_frame(input string tag, input int pat, input int d, input int nf_at);
      int  req0, fin0, we0, seq0, err0, mism, off;
      bit  ok;
      req0 = req_total; fin0 = fin_total; we0 = we_total;
      seq0 = seq_err;   err0 = proto_err;
      off = model_off();
      start_frame(pat, d, ok);
      chk({tag, "_request_seen"}, int'(ok), 1);
      if (nf_at >= 0) begin
         wait_writes(nf_at, ok);
         chk({tag, "_reach_write"}, int'(ok), 1);
         new_frame_initiated = 1'b1;
         @(negedge clk);
         new_frame_initiated = 1'b0;
      end
      wait_finish(ok);
      chk({tag, "_finish_seen"}, int'(ok), 1);
      repeat (3) @(negedge clk);
      chk({tag, "_request_cycles"}, req_total - req0, d);
      chk({tag, "_write_count"}, we_total - we0, NPIX);
      chk({tag, "_address_order"}, seq_err - seq0, 0);
      chk({tag, "_protocol"}, proto_err - err0, 0);
      chk({tag, "_finished_pulses"}, fin_total - fin0, 1);
      mism = 0;
      for (int v = 0; v < V; v++)
         for (int h = 0; h < H; h++)
            if (fb[v * H + h] !== 14'(model_px(pat, h, v, off))) mism++;
      chk({tag, "_pixel_mismatches"}, mism, 0);
      chk({tag, "_pool_empty_after"}, int'(drawing_pool_empty), 1);
      frames_done++;
   endtask

   initial begin
      int  y, fin0, pat;
      bit  ok;
      int  anim_exp;

      // Reset held three cycles, then ten idle cycles.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      frames_done = 0;
      repeat (10) @(negedge clk);
      chk("idle_request", int'(write_reservation_request), 0);
      chk("idle_write_en", int'(write_en), 0);
      chk("idle_horiz", int'(horiz_write_addr), 0);
      chk("idle_vert", int'(vert_write_addr), 0);
      chk("idle_data", int'(write_pixel_data), 0);
      chk("idle_finished", int'(finished), 0);
      chk("idle_pool_empty", int'(drawing_pool_empty), 1);
      chk("idle_overrun", int'(overrun), 0);

      // Checker frame with a five-cycle grant delay.
      do_frame("checker", 2, 5, -1);
      chk("checker_8_0", int'(fb[0 * H + 8]), 'hFFF);
      chk("checker_8_8", int'(fb[8 * H + 8]), 'h000);

      // Colour bars, random grant delay, random row for spot checks.
      do_frame("bars", 1, $urandom_range(1, 8), -1);
      y = $urandom_range(0, V - 1);
      chk("bars_0_y", int'(fb[y * H + 0]), 'h000);
      chk("bars_10_y", int'(fb[y * H + 10]), 'h00F);
      chk("bars_79_y", int'(fb[y * H + 79]), 'hFFF);

      // Random patterns.
      do_frame("rand_a", $urandom_range(0, 3), $urandom_range(1, 8), -1);
      do_frame("rand_b", $urandom_range(0, 3), $urandom_range(1, 8), -1);

      // New frame during draw: ignored for drawing, flags overrun.
      chk("overrun_before", int'(overrun), 0);
      do_frame("overrun", $urandom_range(0, 3), $urandom_range(1, 8), 100);
      chk("overrun_set", int'(overrun), 1);
      repeat (10) @(negedge clk);
      chk("overrun_sticky", int'(overrun), 1);
      chk("overrun_no_restart", int'(write_reservation_request), 0);

      // Reset during draw aborts the frame.
      fin0 = fin_total;
      pat = $urandom_range(0, 3);
      start_frame(pat, $urandom_range(1, 8), ok);
      chk("abort_request_seen", int'(ok), 1);
      wait_writes(2000, ok);
      chk("abort_reach_write", int'(ok), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_write_en", int'(write_en), 0);
      chk("abort_pool_empty", int'(drawing_pool_empty), 1);
      rst = 1'b0;
      frames_done = 0;
      repeat (10) @(negedge clk);
      chk("abort_burst_len", burst_len, 2000);
      chk("abort_no_finished", fin_total - fin0, 0);
      chk("abort_overrun_cleared", int'(overrun), 0);
      do_frame("after_abort", $urandom_range(0, 3), $urandom_range(1, 8), -1);

      // Gradient frames back to back; offset advances only when animated.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frames_done = 0;
      do_frame("grad_f1", 3, $urandom_range(1, 8), -1);
      chk("grad_f1_0_0", int'(fb[0]), 'h000);
      do_frame("grad_f2", 3, $urandom_range(1, 8), -1);
`ifdef GFG_PATTERN_ANIMATE_EN
      anim_exp = 'h101;
`else
      anim_exp = 'h000;
`endif
      chk("grad_f2_0_0", int'(fb[0]), anim_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gfg_pattern_rasterizer.md
GFG_PATTERN_RASTERIZER -- requirements
Module: gfg_pattern_rasterizer

Interface
REQ-001 Parameters:
- HORIZ_RESOLUTION, 80, frame buffer columns.
- VERT_RESOLUTION, 60, frame buffer rows.
- COLOR_DEPTH, 12, RGB bits; fixed at 4:4:4.
- Z_DEPTH, 2, depth bits.

REQ-002 Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- new_frame_initiated  in  1  frame buffers swapped, new draw frame open.
- pattern_sel  in  2  pattern select.
- write_reservation_granted  in  1  frame buffer grants write access.
- write_reservation_request  out  1  request write access.
- vert_write_addr  out  $clog2(VERT_RESOLUTION)  row.
- horiz_write_addr  out  $clog2(HORIZ_RESOLUTION)  column.
- write_en  out  1  pixel write strobe.
- write_pixel_data  out  Z_DEPTH+COLOR_DEPTH  {z, r[3:0], g[3:0], b[3:0]}.
- finished  out  1  one-cycle frame-complete pulse.
- drawing_pool_empty  out  1  high when not drawing.
- overrun  out  1  sticky: new frame arrived while busy.

Function
REQ-003 FSM states are IDLE, REQUEST, DRAW and DONE.
REQ-004 IDLE: on new_frame_initiated=1, latch pattern_sel, go to REQUEST next cycle.
REQ-005 REQUEST: write_reservation_request=1 held until write_reservation_granted=1 is sampled; then go to DRAW with addresses (0,0).
REQ-006 DRAW: write_en=1 every cycle. Address, data and write_en are registered and change on the same edge (zero relative skew). Horiz increments 0..HORIZ_RESOLUTION-1, then wraps to 0 and vert increments.
REQ-007 The pixel at (HORIZ_RESOLUTION-1, VERT_RESOLUTION-1) is written, then DONE follows. Exactly HORIZ_RESOLUTION*VERT_RESOLUTION writes per frame, none out of range.
REQ-008 DONE: finished=1 for one cycle, write_en=0, go to IDLE.
REQ-009 drawing_pool_empty=1 in IDLE and DONE; 0 in REQUEST and DRAW.
REQ-010 new_frame_initiated in REQUEST, DRAW or DONE is ignored for drawing and sets overrun=1. It does not restart the frame.
REQ-011 Pattern 0 (solid): rgb=12'h00F.
REQ-012 Pattern 1 (bars): b=horiz/(HORIZ_RESOLUTION/8); r,g,b = b[2],b[1],b[0] ? 4'hF : 4'h0.
REQ-013 Pattern 2 (checker): horiz[3]^vert[3] ? 12'hFFF : 12'h000.
REQ-014 Pattern 3 (gradient): r=(horiz+offset)[3:0], g=vert[3:0], b=offset[3:0]. Additions wrap modulo 16.
REQ-015 The z field is always zero.
REQ-016 write_pixel_data is 0 whenever write_en=0.

Reset
REQ-017 While rst=1 at a clock edge, the next state is IDLE and every output is 0, except drawing_pool_empty=1. This includes overrun, addresses and offset.
REQ-018 Reset mid-DRAW aborts the frame: no further write_en and no finished pulse.

Configuration
REQ-019 Macro GFG_PATTERN_ANIMATE_EN, when defined, enables an 8-bit offset register. It increments by 1 (wrapping 255->0) on each cycle in DONE.
REQ-020 When the macro is undefined, offset is constant 0 and no register exists.

Structure
REQ-021 Package gfg_pkg holds:
- the FSM state enum;
- pattern code constants (PAT_SOLID=0, PAT_BARS=1, PAT_CHECKER=2, PAT_GRADIENT=3);
- FRAME_BUFFER_WIDTH.
REQ-022 One combinational sub-module, gfg_pattern_color, maps (pattern, horiz, vert, offset) to rgb.

Verification
REQ-023 Reset then idle: rst held 3 cycles, then 10 idle cycles -> all outputs 0, drawing_pool_empty=1.
REQ-024 Full frame with pattern 2 and grant delayed 5 cycles:
- request stays high 5 cycles;
- exactly 4800 writes follow;
- (8,0)=12'hFFF and (8,8)=12'h000;
- one finished pulse.
REQ-025 Pattern 1: (0,y)=12'h000, (10,y)=12'h00F, (79,y)=12'hFFF.
REQ-026 new_frame_initiated pulsed at write 100 -> frame still ends at write 4800 and overrun=1 until reset.
REQ-027 rst asserted after write 2000 -> write_en=0 next cycle, no finished pulse, and the next frame restarts at (0,0).
REQ-028 GFG_PATTERN_ANIMATE_EN defined, pattern 3, two frames -> frame 2 pixel (0,0) rgb=12'h101. Undefined -> 12'h000 both frames.
